// File: rtl/hazard_stall_unit_if.sv
// Hazard unit <-> pipeline bundle: ID-stage metadata in,
// stall/bubble/flush and tracked register numbers out.
interface hazard_stall_unit_if #(
  parameter int REG_W = 5
);
  logic             ID_valid;
  logic [REG_W-1:0] ID_Rn;
  logic [REG_W-1:0] ID_Rm;
  logic [REG_W-1:0] ID_Rd;
  logic             ID_useRn;
  logic             ID_useRm;
  logic             ID_RegWrite;
  logic             ID_MemRead;
  logic             ID_isCB;
  logic             ID_brTaken;

  logic             stall;
  logic             bubble;
  logic             flush;
  logic [REG_W-1:0] IDEX_Rd;
  logic [REG_W-1:0] IDEX_Rn;
  logic [REG_W-1:0] IDEX_Rm;
  logic [REG_W-1:0] EXMEM_Rd;
  logic [REG_W-1:0] MEMWB_Rd;
  logic             EXMEM_RegWrite;
  logic             MEMWB_RegWrite;

  modport master (
    output ID_valid, ID_Rn, ID_Rm, ID_Rd,
    output ID_useRn, ID_useRm, ID_RegWrite,
    output ID_MemRead, ID_isCB, ID_brTaken,
    input  stall, bubble, flush,
    input  IDEX_Rd, IDEX_Rn, IDEX_Rm,
    input  EXMEM_Rd, MEMWB_Rd,
    input  EXMEM_RegWrite, MEMWB_RegWrite
  );

  modport slave (
    input  ID_valid, ID_Rn, ID_Rm, ID_Rd,
    input  ID_useRn, ID_useRm, ID_RegWrite,
    input  ID_MemRead, ID_isCB, ID_brTaken,
    output stall, bubble, flush,
    output IDEX_Rd, IDEX_Rn, IDEX_Rm,
    output EXMEM_Rd, MEMWB_Rd,
    output EXMEM_RegWrite, MEMWB_RegWrite
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// LEGv8 load-use / CBZ hazard detector with shadow pipeline.
// Optional stall/flush counters under HAZ_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic clk,
  input  logic reset,
  hazard_stall_unit_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic             reg_write;
    logic             mem_read;
  } id_ex_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } mem_wb_t;

  localparam id_ex_t  IDEX_NOP  = '{ZR, ZR, ZR, 1'b0, 1'b0};
  localparam ex_mem_t EXMEM_NOP = '{ZR, 1'b0, 1'b0};
  localparam mem_wb_t MEMWB_NOP = '{ZR, 1'b0};

  id_ex_t  idex_q;
  ex_mem_t exmem_q;
  mem_wb_t memwb_q;
  logic    first_q;

  logic lu;
  logic cb1;
  logic cb2;
  logic stall_raw;
  logic bubble_raw;
  logic quiet;
  id_ex_t idex_d;

  always_comb begin
    lu = idex_q.mem_read && idex_q.rd != ZR &&
         ((hz.ID_useRn && hz.ID_Rn == idex_q.rd) ||
          (hz.ID_useRm && hz.ID_Rm == idex_q.rd));
    cb1 = hz.ID_isCB && idex_q.reg_write &&
          hz.ID_Rm != ZR && idex_q.rd == hz.ID_Rm;
    cb2 = hz.ID_isCB && exmem_q.mem_read &&
          hz.ID_Rm != ZR && exmem_q.rd == hz.ID_Rm;
    stall_raw  = hz.ID_valid && (lu || cb1 || cb2);
    bubble_raw = stall_raw || !hz.ID_valid;
    // Controls stay quiet during reset and the cycle after it.
    quiet = reset || first_q;
  end

  always_comb begin
    idex_d = IDEX_NOP;
    if (!bubble_raw) begin
      idex_d.rd        = hz.ID_Rd;
      idex_d.rn        = hz.ID_Rn;
      idex_d.rm        = hz.ID_Rm;
      idex_d.reg_write = hz.ID_RegWrite;
      idex_d.mem_read  = hz.ID_MemRead;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= IDEX_NOP;
      exmem_q <= EXMEM_NOP;
      memwb_q <= MEMWB_NOP;
      first_q <= 1'b1;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= '{idex_q.rd, idex_q.reg_write,
                   idex_q.mem_read};
      memwb_q <= '{exmem_q.rd, exmem_q.reg_write};
      first_q <= 1'b0;
    end
  end

  assign hz.stall  = !quiet && stall_raw;
  assign hz.bubble = !quiet && bubble_raw;
  assign hz.flush  = !quiet && hz.ID_valid &&
                     hz.ID_isCB && hz.ID_brTaken &&
                     !stall_raw;

  assign hz.IDEX_Rd        = idex_q.rd;
  assign hz.IDEX_Rn        = idex_q.rn;
  assign hz.IDEX_Rm        = idex_q.rm;
  assign hz.EXMEM_Rd       = exmem_q.rd;
  assign hz.EXMEM_RegWrite = exmem_q.reg_write;
  assign hz.MEMWB_Rd       = memwb_q.rd;
  assign hz.MEMWB_RegWrite = memwb_q.reg_write;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (hz.flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: reset, load-use,
// CBZ dependencies, XZR, and mid-stall reset.
module tb_hazard_stall_unit;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  hazard_stall_unit_if #(.REG_W(5)) h ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_stall_unit #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (h.slave)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ck_b(input string tag,
                      input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b",
                tag, obs, exp);
  endtask

  task automatic ck_r(input string tag,
                      input logic [4:0] obs,
                      input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic ck_w(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic ck_ctl(input string tag, input logic s,
                        input logic b, input logic f);
    ck_b({tag, ".stall"}, h.stall, s);
    ck_b({tag, ".bubble"}, h.bubble, b);
    ck_b({tag, ".flush"}, h.flush, f);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] rn, rm, rd,
                       input logic urn, urm, rw, mr,
                       input logic cb, br);
    h.ID_valid    = v;
    h.ID_Rn       = rn;
    h.ID_Rm       = rm;
    h.ID_Rd       = rd;
    h.ID_useRn    = urn;
    h.ID_useRm    = urm;
    h.ID_RegWrite = rw;
    h.ID_MemRead  = mr;
    h.ID_isCB     = cb;
    h.ID_brTaken  = br;
    #1;
  endtask

  task automatic idle;
    drive(0, 31, 31, 31, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ldur(input logic [4:0] rd);
    drive(1, 1, 31, rd, 1, 0, 1, 1, 0, 0);
  endtask

  task automatic add(input logic [4:0] rd,
                     input logic [4:0] rn,
                     input logic [4:0] rm);
    drive(1, rn, rm, rd, 1, 1, 1, 0, 0, 0);
  endtask

  task automatic cbz(input logic [4:0] rt, input logic br);
    drive(1, 31, rt, 31, 0, 1, 0, 0, 1, br);
  endtask

  task automatic drain;
    idle;
    repeat (3) tick;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    idle;

    // Reset held three cycles, then idle.
    for (int i = 0; i < 3; i++) begin
      ck_ctl("rst", 0, 0, 0);
      tick;
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      ck_ctl("idle", 0, (i != 0), 0);
      ck_r("idle.idex_rd", h.IDEX_Rd, 31);
      ck_r("idle.exmem_rd", h.EXMEM_Rd, 31);
      ck_r("idle.memwb_rd", h.MEMWB_Rd, 31);
      ck_b("idle.exmem_rw", h.EXMEM_RegWrite, 0);
      ck_b("idle.memwb_rw", h.MEMWB_RegWrite, 0);
      tick;
    end

    // LDUR X2 ; ADD X3,X2,X4
    ldur(2);
    ck_ctl("lu.ld", 0, 0, 0);
    tick;
    add(3, 2, 4);
    ck_ctl("lu.use", 1, 1, 0);
    tick;
    ck_ctl("lu.go", 0, 0, 0);
    ck_r("lu.bub_rd", h.IDEX_Rd, 31);
    ck_r("lu.exmem_rd", h.EXMEM_Rd, 2);
    ck_b("lu.exmem_rw", h.EXMEM_RegWrite, 1);
    tick;
    idle;
    ck_r("lu.idex_rn", h.IDEX_Rn, 2);
    ck_r("lu.idex_rd", h.IDEX_Rd, 3);
    ck_r("lu.idex_rm", h.IDEX_Rm, 4);
    ck_b("lu.memwb_rw", h.MEMWB_RegWrite, 1);
`ifdef HAZ_PERF_CNT_EN
    ck_w("lu.stall_cnt", stall_cnt, 32'd1);
`endif
    drain;

    // LDUR X5 ; CBZ X5 taken -> two stalls then flush
    ldur(5);
    tick;
    cbz(5, 1);
    ck_ctl("lcb.s1", 1, 1, 0);
    tick;
    ck_ctl("lcb.s2", 1, 1, 0);
    tick;
    ck_ctl("lcb.go", 0, 0, 1);
    tick;
    idle;
    ck_r("lcb.idex_rm", h.IDEX_Rm, 5);
    drain;

    // ADD X7 ; CBZ X7 -> one stall
    add(7, 1, 2);
    tick;
    cbz(7, 0);
    ck_ctl("acb.s1", 1, 1, 0);
    tick;
    ck_ctl("acb.go", 0, 0, 0);
    tick;
    drain;

    // ADD X7 ; ADD X8 ; CBZ X7 taken -> no stall
    add(7, 1, 2);
    tick;
    add(8, 9, 10);
    ck_ctl("d2.mid", 0, 0, 0);
    tick;
    cbz(7, 1);
    ck_ctl("d2.cbz", 0, 0, 1);
    tick;
    drain;

    // LDUR X31 ; ADD X1,X31,X31 -> XZR never hazards
    drive(1, 1, 31, 31, 1, 0, 1, 1, 0, 0);
    tick;
    add(1, 31, 31);
    ck_ctl("xzr.use", 0, 0, 0);
    tick;
    idle;
    ck_r("xzr.exmem_rd", h.EXMEM_Rd, 31);
    ck_b("xzr.exmem_rw", h.EXMEM_RegWrite, 1);
    drain;

    // Reset during the second CBZ stall
    ldur(5);
    tick;
    cbz(5, 1);
    tick;
    ck_ctl("mrst.pre", 1, 1, 0);
    reset = 1'b1;
    #1;
    ck_ctl("mrst.hi", 0, 0, 0);
    tick;
    ck_ctl("mrst.after", 0, 0, 0);
    ck_r("mrst.idex_rd", h.IDEX_Rd, 31);
    ck_r("mrst.exmem_rd", h.EXMEM_Rd, 31);
    ck_r("mrst.memwb_rd", h.MEMWB_Rd, 31);
    ck_b("mrst.memwb_rw", h.MEMWB_RegWrite, 0);
    reset = 1'b0;
    #1;
    ck_ctl("mrst.first", 0, 0, 0);
`ifdef HAZ_PERF_CNT_EN
    ck_w("mrst.stall_cnt", stall_cnt, 32'd0);
    ck_w("mrst.flush_cnt", flush_cnt, 32'd0);
`endif
    tick;
    ck_ctl("mrst.cbz", 0, 0, 1);
    tick;
    idle;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
